// File: rtl/test_mem_mp.sv
// Multi-port word-addressed test memory with val/rdy request/response channels.
// Optional per-port LFSR request stalling is enabled by defining TEST_MEM_MP_STALL_EN.
module test_mem_mp #(
    parameter int unsigned P       = 2,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [P-1:0]      req_val,
    output logic [P-1:0]      req_rdy,
    input  logic [P-1:0]      req_op,
    input  logic [32*P-1:0]   req_addr,
    input  logic [32*P-1:0]   req_data,
    input  logic [4*P-1:0]    req_strb,
    output logic [P-1:0]      resp_val,
    input  logic [P-1:0]      resp_rdy,
    output logic [32*P-1:0]   resp_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [31:0]  mem [DEPTH];
    logic [P-1:0] acc;
    logic [P-1:0] credit_ok;
    logic [P-1:0] stall;

    assign req_rdy = credit_ok & ~stall;
    assign acc     = req_val & req_rdy;

    // Later non-blocking writes override earlier ones, so the highest port wins per byte.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < P; p++) begin
            if (acc[p] && req_op[p]) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (req_strb[4*p + b])
                        mem[req_addr[32*p + 2 +: AW]][8*b +: 8] <= req_data[32*p + 8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_port
        logic [AW-1:0] idx;
        logic [31:0]   rd_word;
        logic [31:0]   push_d;
        logic          push_v;
        logic          pop;
        logic [31:0]   fd [MAX_OUT];
        logic [PW-1:0] wp;
        logic [PW-1:0] rp;
        logic [CW-1:0] fcnt;
        logic [CW-1:0] outst;
        logic          addr_unused;

        assign idx         = req_addr[32*g + 2 +: AW];
        assign addr_unused = ^{req_addr[32*g + 31 : 32*g + 2 + AW], req_addr[32*g + 1 : 32*g]};
        assign rd_word     = req_op[g] ? '0 : mem[idx];
        assign pop         = resp_val[g] & resp_rdy[g];

        // The FIFO register itself is the final delay stage, so only LATENCY-1 extra stages precede it.
        if (LATENCY == 1) begin : g_direct
            assign push_v = acc[g];
            assign push_d = rd_word;
        end else begin : g_delay
            logic [LATENCY-2:0] dv;
            logic [31:0]        dd [LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dv <= '0;
                    for (int unsigned i = 0; i < LATENCY - 1; i++) dd[i] <= '0;
                end else begin
                    dv[0] <= acc[g];
                    dd[0] <= rd_word;
                    for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                        dv[i] <= dv[i-1];
                        dd[i] <= dd[i-1];
                    end
                end
            end

            assign push_v = dv[LATENCY-2];
            assign push_d = dd[LATENCY-2];
        end

        always_ff @(posedge clk) begin
            if (push_v) fd[wp] <= push_d;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp    <= '0;
                rp    <= '0;
                fcnt  <= '0;
                outst <= '0;
            end else begin
                if (push_v) wp <= (wp == PW'(MAX_OUT - 1)) ? '0 : wp + 1'b1;
                if (pop)    rp <= (rp == PW'(MAX_OUT - 1)) ? '0 : rp + 1'b1;
                fcnt  <= fcnt + CW'(push_v) - CW'(pop);
                outst <= outst + CW'(acc[g]) - CW'(pop);
            end
        end

        assign resp_val[g]             = rst & (fcnt != '0);
        assign resp_data[32*g +: 32]   = fd[rp];
        assign credit_ok[g]            = rst & (outst < CW'(MAX_OUT));

`ifdef TEST_MEM_MP_STALL_EN
        logic [15:0] lfsr;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) lfsr <= 16'hACE1 ^ 16'(g);
            else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end

        assign stall[g] = (lfsr[1:0] == 2'b00);
`else
        assign stall[g] = 1'b0;
`endif
    end
endmodule
